// File: rtl/alu_pkg.sv
// Shared ALU definitions: ALUop and funct3 encodings,
// arbiter FSM states and the funct3/ALUop legality check.
package alu_pkg;

    localparam logic [4:0] OP_ADD  = 5'b00000;
    localparam logic [4:0] OP_SUB  = 5'b01000;
    localparam logic [4:0] OP_SLL  = 5'b00001;
    localparam logic [4:0] OP_SLT  = 5'b00100;
    localparam logic [4:0] OP_SLTU = 5'b00101;
    localparam logic [4:0] OP_XOR  = 5'b00110;
    localparam logic [4:0] OP_SRL  = 5'b00111;
    localparam logic [4:0] OP_SRA  = 5'b10111;
    localparam logic [4:0] OP_OR   = 5'b01010;
    localparam logic [4:0] OP_AND  = 5'b01100;

    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_SLL  = 3'b001;
    localparam logic [2:0] F3_SLT  = 3'b010;
    localparam logic [2:0] F3_SLTU = 3'b011;
    localparam logic [2:0] F3_XOR  = 3'b100;
    localparam logic [2:0] F3_SR   = 3'b101;
    localparam logic [2:0] F3_OR   = 3'b110;
    localparam logic [2:0] F3_AND  = 3'b111;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_RESP = 2'd2
    } state_t;

    function automatic logic pair_legal(input logic [2:0] f3,
                                        input logic [4:0] op);
        logic ok;
        ok = 1'b0;
        case (f3)
            F3_ADD:  ok = (op == OP_ADD) || (op == OP_SUB);
            F3_SLL:  ok = (op == OP_SLL);
            F3_SLT:  ok = (op == OP_SLT);
            F3_SLTU: ok = (op == OP_SLTU);
            F3_XOR:  ok = (op == OP_XOR);
            F3_SR:   ok = (op == OP_SRL) || (op == OP_SRA);
            F3_OR:   ok = (op == OP_OR);
            F3_AND:  ok = (op == OP_AND);
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/alu.sv
// Shared single-cycle combinational ALU.
// SLT and SLTU both compare unsigned.
module alu
    import alu_pkg::*;
#(
    parameter int W = 32
) (
    input  logic [4:0]   aluop,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] result
);

    always_comb begin
        result = '0;
        case (aluop)
            OP_ADD:  result = a + b;
            OP_SUB:  result = a - b;
            OP_SLL:  result = a << b[4:0];
            OP_SLT:  result = {{(W-1){1'b0}}, (a < b)};
            OP_SLTU: result = {{(W-1){1'b0}}, (a < b)};
            OP_XOR:  result = a ^ b;
            OP_SRL:  result = a >> b[4:0];
            OP_SRA:  result = $unsigned($signed(a) >>> b[4:0]);
            OP_OR:   result = a | b;
            OP_AND:  result = a & b;
            default: result = '0;
        endcase
    end

endmodule

// File: rtl/alu_share_arbiter_rr_pick.sv
// Round-robin selector: first set request at or after ptr,
// wrapping modulo N. Outputs one-hot grant and its index.
module rr_pick #(
    parameter int N  = 2,
    parameter int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [PW-1:0] idx
);

    always_comb begin : pick
        int   j;
        logic found;
        gnt   = '0;
        idx   = '0;
        found = 1'b0;
        j     = 0;
        for (int k = 0; k < N; k++) begin
            j = int'(ptr) + k;
            if (j >= N) j = j - N;
            if (!found && req[j]) begin
                found  = 1'b1;
                gnt[j] = 1'b1;
                idx    = PW'(j);
            end
        end
    end

endmodule

// File: rtl/alu_share_arbiter.sv
// Round-robin sharing of one combinational ALU between NREQ
// requesters: grant, capture, evaluate, hold result until taken.
module alu_share_arbiter
    import alu_pkg::*;
#(
    parameter int NREQ = 2,
    parameter int W    = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req_valid,
    output logic [NREQ-1:0]   req_ready,
    input  logic [3*NREQ-1:0] req_funct3,
    input  logic [5*NREQ-1:0] req_aluop,
    input  logic [W*NREQ-1:0] req_a,
    input  logic [W*NREQ-1:0] req_b,
    output logic [NREQ-1:0]   rsp_valid,
    input  logic [NREQ-1:0]   rsp_ready,
    output logic [W-1:0]      rsp_result,
    output logic              rsp_zero,
    output logic              rsp_illegal,
    output logic              busy
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    state_t        state, state_nx;
    logic [PW-1:0] rr_ptr, cap_g, pick_idx;
    logic [NREQ-1:0] pick_gnt;
    logic [2:0]    cap_f3;
    logic [4:0]    cap_op;
    logic [W-1:0]  cap_a, cap_b, alu_y;
    logic          legal, rsp_hs, grant;

    rr_pick #(.N(NREQ), .PW(PW)) u_pick (
        .req (req_valid),
        .ptr (rr_ptr),
        .gnt (pick_gnt),
        .idx (pick_idx)
    );

    // ALU sees only the capture register, never live requester fields
    alu #(.W(W)) u_alu (
        .aluop  (cap_op),
        .a      (cap_a),
        .b      (cap_b),
        .result (alu_y)
    );

    assign legal  = pair_legal(cap_f3, cap_op);
    assign rsp_hs = rsp_ready[cap_g];
    assign grant  = (state == S_IDLE) && (|req_valid);
    assign busy   = (state != S_IDLE);

    always_comb begin
        state_nx  = state;
        req_ready = '0;
        rsp_valid = '0;
        unique case (state)
            S_IDLE: begin
                req_ready = pick_gnt;
                if (|req_valid) state_nx = S_EXEC;
            end
            S_EXEC: state_nx = S_RESP;
            S_RESP: begin
                rsp_valid[cap_g] = 1'b1;
                if (rsp_hs) state_nx = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            rr_ptr      <= '0;
            cap_g       <= '0;
            cap_f3      <= '0;
            cap_op      <= '0;
            cap_a       <= '0;
            cap_b       <= '0;
            rsp_result  <= '0;
            rsp_zero    <= 1'b0;
            rsp_illegal <= 1'b0;
        end else begin
            state <= state_nx;
            if (grant) begin
                cap_g  <= pick_idx;
                cap_f3 <= req_funct3[int'(pick_idx)*3 +: 3];
                cap_op <= req_aluop[int'(pick_idx)*5 +: 5];
                cap_a  <= req_a[int'(pick_idx)*W +: W];
                cap_b  <= req_b[int'(pick_idx)*W +: W];
            end
            if (state == S_EXEC) begin
                rsp_result  <= legal ? alu_y : '0;
                rsp_zero    <= legal ? (alu_y == '0) : 1'b1;
                rsp_illegal <= !legal;
            end
            if (state == S_RESP && rsp_hs) begin
                rr_ptr <= (cap_g == PW'(NREQ-1)) ? '0 : cap_g + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Scoreboard bench for alu_share_arbiter: drivers push expected
// responses on grant, a negedge monitor checks protocol and data.
module tb_alu_share_arbiter;

    localparam int NREQ = 2;
    localparam int W    = 32;

    typedef struct {
        logic [W-1:0] res;
        logic         zero;
        logic         ill;
    } exp_t;

    logic              clk, rst;
    logic [NREQ-1:0]   req_valid, req_ready, rsp_valid, rsp_ready;
    logic [3*NREQ-1:0] req_funct3;
    logic [5*NREQ-1:0] req_aluop;
    logic [W*NREQ-1:0] req_a, req_b;
    logic [W-1:0]      rsp_result;
    logic              rsp_zero, rsp_illegal, busy;

    int   nvec = 0;
    int   nerr = 0;
    exp_t q[NREQ][$];
    int   rdy_mode = 0;

    bit   inflight = 0;
    int   stage = 0;
    int   gcur = 0;
    int   mptr = 0;
    int   cyc = 0;
    int   last_gnt = -1;
    bit   contend = 0;

    logic [7:0] legal_pairs [10] = '{
        8'b000_00000, 8'b000_01000, 8'b001_00001, 8'b010_00100,
        8'b011_00101, 8'b100_00110, 8'b101_00111, 8'b101_10111,
        8'b110_01010, 8'b111_01100
    };

    alu_share_arbiter #(.NREQ(NREQ), .W(W)) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_funct3  (req_funct3),
        .req_aluop   (req_aluop),
        .req_a       (req_a),
        .req_b       (req_b),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_result  (rsp_result),
        .rsp_zero    (rsp_zero),
        .rsp_illegal (rsp_illegal),
        .busy        (busy)
    );

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(string nm, logic [W-1:0] act, logic [W-1:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got 0x%0h want 0x%0h (t=%0t)",
                     nm, act, exp, $time);
        end
    endtask

    function automatic exp_t ref_op(logic [2:0] f3, logic [4:0] op,
                                    logic [W-1:0] a, logic [W-1:0] b);
        exp_t e;
        logic [W-1:0] r;
        logic ok;
        int s;
        s  = int'(b[4:0]);
        ok = 1'b1;
        r  = '0;
        case ({f3, op})
            8'b000_00000: r = a + b;
            8'b000_01000: r = a - b;
            8'b001_00001: r = a << s;
            8'b010_00100: r = (a < b) ? 1 : 0;
            8'b011_00101: r = (a < b) ? 1 : 0;
            8'b100_00110: r = a ^ b;
            8'b101_00111: r = a >> s;
            8'b101_10111: r = (a >> s) | (a[W-1] ? ~({W{1'b1}} >> s) : '0);
            8'b110_01010: r = a | b;
            8'b111_01100: r = a & b;
            default:      ok = 1'b0;
        endcase
        e.res  = ok ? r : '0;
        e.zero = (e.res == '0);
        e.ill  = !ok;
        return e;
    endfunction

    function automatic int ref_pick(logic [NREQ-1:0] v, int p);
        for (int k = 0; k < NREQ; k++) begin
            if (v[(p + k) % NREQ]) return (p + k) % NREQ;
        end
        return -1;
    endfunction

    // Requester driver: present fields, hold until granted
    task automatic issue(int i, logic [2:0] f3, logic [4:0] op,
                         logic [W-1:0] a, logic [W-1:0] b);
        bit got;
        got = 0;
        req_funct3[3*i +: 3] = f3;
        req_aluop[5*i +: 5]  = op;
        req_a[W*i +: W]      = a;
        req_b[W*i +: W]      = b;
        req_valid[i]         = 1'b1;
        for (int n = 0; n < 300 && !got; n++) begin
            @(negedge clk);
            if (req_ready[i]) got = 1;
        end
        if (got) begin
            q[i].push_back(ref_op(f3, op, a, b));
        end else begin
            nvec++;
            nerr++;
            $display("FAIL grant_timeout: req%0d got no grant want grant", i);
        end
        @(posedge clk);
        #1;
        req_valid[i] = 1'b0;
    endtask

    task automatic rand_issue(int i);
        logic [7:0]   p;
        logic [W-1:0] a, b;
        if ($urandom_range(0, 9) < 8)
            p = legal_pairs[$urandom_range(0, 9)];
        else
            p = 8'($urandom);
        a = $urandom;
        b = $urandom;
        case ($urandom_range(0, 5))
            0: a = '1;
            1: b = a;
            2: b = 32'($urandom_range(0, 40));
            default: ;
        endcase
        issue(i, p[7:5], p[4:0], a, b);
    endtask

    task automatic wait_idle();
        bit done;
        done = 0;
        for (int n = 0; n < 500 && !done; n++) begin
            @(negedge clk);
            if (!inflight && !busy && req_valid == '0 &&
                q[0].size() == 0 && q[1].size() == 0) done = 1;
        end
        if (!done) begin
            nvec++;
            nerr++;
            $display("FAIL idle_timeout: block still busy want idle");
        end
        @(posedge clk);
        #1;
    endtask

    task automatic reset_checks(string tag);
        @(negedge clk);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
        chk({tag, "_req_ready"}, 32'(req_ready), 32'd0);
        chk({tag, "_result"}, rsp_result, 32'd0);
        chk({tag, "_zero"}, 32'(rsp_zero), 32'd0);
        chk({tag, "_illegal"}, 32'(rsp_illegal), 32'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        rsp_ready = '0;
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0:       rsp_ready = '1;
                1:       rsp_ready = NREQ'($urandom);
                2:       rsp_ready = '0;
                default: rsp_ready = NREQ'(1);
            endcase
        end
    end

    // Monitor: expected protocol from a grant/latency model
    always @(negedge clk) begin
        int pg;
        cyc++;
        if (rst) begin
            inflight = 0;
            mptr     = 0;
            for (int i = 0; i < NREQ; i++) q[i].delete();
        end else if (!inflight) begin
            pg = ref_pick(req_valid, mptr);
            chk("idle_busy", 32'(busy), 32'd0);
            chk("idle_rsp_valid", 32'(rsp_valid), 32'd0);
            chk("grant", 32'(req_ready), (pg < 0) ? 32'd0 : (32'd1 << pg));
            if (pg >= 0) begin
                if (contend && last_gnt >= 0)
                    chk("issue_interval", 32'(cyc - last_gnt), 32'd3);
                last_gnt = cyc;
                inflight = 1;
                stage    = 0;
                gcur     = pg;
            end
        end else if (stage == 0) begin
            chk("exec_busy", 32'(busy), 32'd1);
            chk("exec_req_ready", 32'(req_ready), 32'd0);
            chk("exec_rsp_valid", 32'(rsp_valid), 32'd0);
            stage = 1;
        end else begin
            chk("resp_busy", 32'(busy), 32'd1);
            chk("resp_req_ready", 32'(req_ready), 32'd0);
            chk("resp_valid", 32'(rsp_valid), 32'd1 << gcur);
            if (q[gcur].size() == 0) begin
                nvec++;
                nerr++;
                $display("FAIL resp_unexpected: req%0d response with empty queue",
                         gcur);
            end else begin
                chk("resp_result", rsp_result, q[gcur][0].res);
                chk("resp_zero", 32'(rsp_zero), 32'(q[gcur][0].zero));
                chk("resp_illegal", 32'(rsp_illegal), 32'(q[gcur][0].ill));
            end
            if (rsp_ready[gcur]) begin
                if (q[gcur].size() != 0) void'(q[gcur].pop_front());
                inflight = 0;
                mptr     = (gcur + 1) % NREQ;
            end
        end
    end

    initial begin
        rst        = 1'b1;
        req_valid  = '0;
        req_funct3 = '0;
        req_aluop  = '0;
        req_a      = '0;
        req_b      = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        reset_checks("por");

        // single request, wrap, shift width, illegal pair
        issue(0, 3'b000, 5'b00000, 32'd5, 32'd7);
        wait_idle();
        issue(0, 3'b000, 5'b00000, 32'hFFFF_FFFF, 32'd1);
        wait_idle();
        issue(1, 3'b001, 5'b00001, 32'd1, 32'h21);
        wait_idle();
        issue(1, 3'b010, 5'b00000, 32'd1, 32'd2);
        wait_idle();

        // contention: both requesters continuously valid
        contend  = 1;
        last_gnt = -1;
        fork
            begin
                repeat (4) issue(0, 3'b000, 5'b01000, 32'd3, 32'd3);
            end
            begin
                repeat (4) issue(1, 3'b000, 5'b01000, 32'd3, 32'd3);
            end
        join
        contend = 0;
        wait_idle();

        // backpressure on requester 1, requester 0 waits
        rdy_mode = 3;
        issue(1, 3'b101, 5'b10111, 32'h8000_0000, 32'd4);
        fork
            issue(0, 3'b100, 5'b00110, 32'h0F0F_0F0F, 32'h00FF_00FF);
            begin
                repeat (10) @(posedge clk);
                rdy_mode = 0;
            end
        join
        wait_idle();

        // reset in EXEC after rr_ptr moved to 1
        issue(0, 3'b000, 5'b00000, 32'd1, 32'd1);
        wait_idle();
        rdy_mode = 2;
        issue(1, 3'b000, 5'b00000, 32'd2, 32'd3);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        reset_checks("rst_exec");
        rdy_mode = 0;
        fork
            issue(0, 3'b110, 5'b01010, 32'h10, 32'h01);
            issue(1, 3'b111, 5'b01100, 32'hF0, 32'h3C);
        join
        wait_idle();

        // reset in RESP after rr_ptr moved to 1
        issue(0, 3'b000, 5'b00000, 32'd4, 32'd4);
        wait_idle();
        rdy_mode = 2;
        issue(0, 3'b100, 5'b00110, 32'd5, 32'd3);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        reset_checks("rst_resp");
        rdy_mode = 0;
        fork
            issue(0, 3'b011, 5'b00101, 32'd1, 32'd9);
            issue(1, 3'b010, 5'b00100, 32'hFFFF_FFFF, 32'd1);
        join
        wait_idle();
        issue(1, 3'b000, 5'b00000, 32'd100, 32'd23);
        wait_idle();

        // randomized traffic with random response backpressure
        rdy_mode = 1;
        fork
            begin
                repeat (25) begin
                    repeat ($urandom_range(0, 3)) @(posedge clk);
                    #1;
                    rand_issue(0);
                end
            end
            begin
                repeat (25) begin
                    repeat ($urandom_range(0, 3)) @(posedge clk);
                    #1;
                    rand_issue(1);
                end
            end
        join
        rdy_mode = 0;
        wait_idle();

        chk("q0_drained", 32'(q[0].size()), 32'd0);
        chk("q1_drained", 32'(q[1].size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
